// File: rtl/i2c_sensor_target_if.sv
// Bus-side signal bundle for the I2C sensor target: raw pad levels, the
// open-drain SDA enable, the live sensor reading and the host-side results.
interface i2c_sensor_target_if;
  logic        scl_in;
  logic        sda_in;
  logic        sda_oe;
  logic [15:0] sensor_data;
  logic [7:0]  write_data;
  logic        write_valid;
  logic        read_done;
  logic        busy;

  // The target (DUT) side
  modport slave (
    input  scl_in, sda_in, sensor_data,
    output sda_oe, write_data, write_valid, read_done, busy
  );

  // The controller / environment side
  modport master (
    output scl_in, sda_in, sensor_data,
    input  sda_oe, write_data, write_valid, read_done, busy
  );
endinterface

// File: rtl/i2c_sensor_target.sv
// I2C target modelling one temperature/light sensor. Answers 2-byte reads
// (MSB first, from a per-transfer snapshot of sensor_data) and 1-byte writes
// at address ADDR. SCL/SDA are oversampled on clk (SCL <= clk/8); SDA is
// driven open-drain through sda_oe, which only changes right after SCL falls.
// Optional: define I2C_TARGET_TIMEOUT_EN to release the bus after SCL has
// been held low for TIMEOUT_CYCLES clk cycles outside IDLE.
module i2c_sensor_target #(
  parameter logic [6:0]  ADDR           = 7'b1001000,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic                 clk,
  input  logic                 rst,
  i2c_sensor_target_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_IGNORE
  } state_t;

  // Synchronizers plus one history flop per line
  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic       timeout;

  // Registered state and its next-state values
  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [15:0] hold_q, hold_d;
  logic        byte_sel_q, byte_sel_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  write_data_q, write_data_d;
  logic        write_valid_q, write_valid_d;
  logic        read_done_q, read_done_d;
  logic        busy_q, busy_d;

  logic [7:0]  shift_in;
  logic [7:0]  next_byte;

  // Bring the pad levels into the clk domain and keep one cycle of history
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: an idle I2C bus is high, so the sync flops reset to 1; resetting
    // them to 0 would fake an SCL/SDA rise (and a STOP) right after reset.
    if (!rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_in};
      sda_sync <= {sda_sync[0], bus.sda_in};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  assign start_det =  scl_s &  sda_d & ~sda_s;
  assign stop_det  =  scl_s & ~sda_d &  sda_s;

  assign shift_in  = {shift_q[6:0], sda_s};
  assign next_byte = byte_sel_q ? hold_q[7:0] : hold_q[15:8];

`ifdef I2C_TARGET_TIMEOUT_EN
  logic [14:0] to_cnt;

  // Count clk cycles of SCL low while a transfer is in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (scl_s || state_q == ST_IDLE || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 15'd1;
    end
  end

  // Fires on the cycle the count would reach TIMEOUT_CYCLES
  assign timeout = !scl_s && (state_q != ST_IDLE) &&
                   (to_cnt >= 15'(TIMEOUT_CYCLES - 1));
`else
  // With the timeout compiled out the target waits on SCL indefinitely;
  // the parameter is still folded into a dummy so it stays referenced.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // Protocol FSM: next state, shift/counter updates and output values
  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    tx_d          = tx_q;
    hold_d        = hold_q;
    byte_sel_d    = byte_sel_q;
    rw_d          = rw_q;
    sda_oe_d      = sda_oe_q;
    write_data_d  = write_data_q;
    write_valid_d = 1'b0;
    read_done_d   = 1'b0;
    busy_d        = busy_q;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      // START wins over any data sample landing in the same cycle
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (timeout) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;

        ST_ADDR: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shift_in[7:1] == ADDR) begin
              state_d    = ST_ADDR_ACK;
              rw_d       = shift_in[0];
              hold_d     = bus.sensor_data;
              byte_sel_d = 1'b0;
              busy_d     = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end

        // First fall starts the ACK, second fall ends it
        ST_ADDR_ACK: if (scl_fall) begin
          bit_cnt_d = '0;
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (rw_q) begin
            state_d  = ST_TX;
            tx_d     = next_byte;
            sda_oe_d = ~next_byte[7];
          end else begin
            state_d  = ST_RX;
            sda_oe_d = 1'b0;
          end
        end

        // Bit 7 went out on entry; each fall presents the next bit
        ST_TX: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            state_d  = ST_TX_ACK;
            sda_oe_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = {tx_q[6:0], 1'b0};
            sda_oe_d  = ~tx_q[6];
          end
        end

        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              read_done_d = 1'b1;
              state_d     = ST_IGNORE;
            end else begin
              byte_sel_d = ~byte_sel_q;
            end
          end else if (scl_fall) begin
            state_d   = ST_TX;
            bit_cnt_d = '0;
            tx_d      = next_byte;
            sda_oe_d  = ~next_byte[7];
          end
        end

        ST_RX: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_RX_ACK;
        end

        ST_RX_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d      = 1'b1;
            write_data_d  = shift_q;
            write_valid_d = 1'b1;
          end else begin
            state_d   = ST_RX;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
          end
        end

        ST_IGNORE: sda_oe_d = 1'b0;

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register for the FSM and its datapath
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop sees
    // pre-edge values regardless of statement order.
    if (!rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      tx_q          <= '0;
      hold_q        <= '0;
      byte_sel_q    <= 1'b0;
      rw_q          <= 1'b0;
      sda_oe_q      <= 1'b0;
      write_data_q  <= '0;
      write_valid_q <= 1'b0;
      read_done_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      tx_q          <= tx_d;
      hold_q        <= hold_d;
      byte_sel_q    <= byte_sel_d;
      rw_q          <= rw_d;
      sda_oe_q      <= sda_oe_d;
      write_data_q  <= write_data_d;
      write_valid_q <= write_valid_d;
      read_done_q   <= read_done_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.sda_oe      = sda_oe_q;
  assign bus.write_data  = write_data_q;
  assign bus.write_valid = write_valid_q;
  assign bus.read_done   = read_done_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_i2c_sensor_target.sv
// Directed bench for i2c_sensor_target: a bit-banged controller on an
// open-drain SDA line, with hand-computed expected bytes, ACKs and pulses.
module tb_i2c_sensor_target;
  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst;
  logic        scl;
  logic        sda_ctrl;
  logic [15:0] sensor;
  logic        sda_line;

  int vectors    = 0;
  int miscompares = 0;

  // Pulse/level monitors, sampled on the falling clk edge
  int   wv_hi   = 0;
  int   rd_hi   = 0;
  int   oe_hi   = 0;
  int   busy_hi = 0;
  logic oe_at_wv = 1'b0;

  i2c_sensor_target_if bus ();

  assign sda_line        = sda_ctrl & ~bus.sda_oe;
  assign bus.scl_in      = scl;
  assign bus.sda_in      = sda_line;
  assign bus.sensor_data = sensor;

  i2c_sensor_target #(.ADDR(7'h48), .TIMEOUT_CYCLES(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.write_valid) begin
      wv_hi    <= wv_hi + 1;
      oe_at_wv <= bus.sda_oe;
    end
    if (bus.read_done) rd_hi   <= rd_hi + 1;
    if (bus.sda_oe)    oe_hi   <= oe_hi + 1;
    if (bus.busy)      busy_hi <= busy_hi + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_ctrl = 1'b1; tick(Q);
    scl      = 1'b1; tick(Q);
    sda_ctrl = 1'b0; tick(Q);
    scl      = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_ctrl = 1'b0; tick(Q);
    scl      = 1'b1; tick(Q);
    sda_ctrl = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_ctrl = b;    tick(Q);
    scl      = 1'b1; tick(2 * Q);
    scl      = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_ctrl = 1'b1; tick(Q);
    scl      = 1'b1; tick(Q);
    b        = sda_line; tick(Q);
    scl      = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] data, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(data[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] data, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      data[i] = b;
    end
    write_bit(nack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic       b;
    int wv0, rd0, oe0, busy0;

    rst = 1'b0; scl = 1'b1; sda_ctrl = 1'b1; sensor = 16'h1A80;
    tick(5);
    check("reset sda_oe",      32'(bus.sda_oe),      32'h0);
    check("reset write_data",  32'(bus.write_data),  32'h0);
    check("reset write_valid", 32'(bus.write_valid), 32'h0);
    check("reset read_done",   32'(bus.read_done),   32'h0);
    check("reset busy",        32'(bus.busy),        32'h0);
    rst = 1'b1;
    tick(5);

    // Read of 0x1A80: ACK byte 1, NACK byte 2
    wv0 = wv_hi; rd0 = rd_hi;
    i2c_start();
    write_byte(8'h91, ack);
    check("rd addr ack", 32'(ack), 32'h0);
    check("rd busy after match", 32'(bus.busy), 32'h1);
    read_byte(d, 1'b0);
    check("rd byte1", 32'(d), 32'h1A);
    read_byte(d, 1'b1);
    check("rd byte2", 32'(d), 32'h80);
    check("rd read_done pulses", 32'(rd_hi - rd0), 32'h1);
    check("rd busy before stop", 32'(bus.busy), 32'h1);
    i2c_stop();
    tick(4);
    check("rd busy after stop", 32'(bus.busy), 32'h0);
    check("rd no write_valid", 32'(wv_hi - wv0), 32'h0);

    // Wrong address 0x49: target stays silent
    wv0 = wv_hi; rd0 = rd_hi; oe0 = oe_hi; busy0 = busy_hi;
    i2c_start();
    write_byte(8'h93, ack);
    check("wa addr nack", 32'(ack), 32'h1);
    read_byte(d, 1'b1);
    check("wa bus idle data", 32'(d), 32'hFF);
    i2c_stop();
    tick(4);
    check("wa sda_oe never", 32'(oe_hi - oe0),     32'h0);
    check("wa busy never",   32'(busy_hi - busy0), 32'h0);
    check("wa no pulses",    32'((wv_hi - wv0) + (rd_hi - rd0)), 32'h0);

    // Single-byte write of 0x5C
    wv0 = wv_hi; rd0 = rd_hi;
    i2c_start();
    write_byte(8'h90, ack);
    check("wr addr ack", 32'(ack), 32'h0);
    write_byte(8'h5C, ack);
    check("wr data ack", 32'(ack), 32'h0);
    i2c_stop();
    tick(4);
    check("wr write_data",        32'(bus.write_data), 32'h5C);
    check("wr write_valid cycles", 32'(wv_hi - wv0),   32'h1);
    check("wr valid with ack",    32'(oe_at_wv),       32'h1);
    check("wr no read_done",      32'(rd_hi - rd0),    32'h0);

    // Snapshot held across a sensor change, third byte wraps to MSB
    rd0 = rd_hi;
    sensor = 16'h1A80;
    i2c_start();
    write_byte(8'h91, ack);
    check("sn addr ack", 32'(ack), 32'h0);
    sensor = 16'h2233;
    read_byte(d, 1'b0);
    check("sn byte1", 32'(d), 32'h1A);
    read_byte(d, 1'b0);
    check("sn byte2", 32'(d), 32'h80);
    read_byte(d, 1'b1);
    check("sn byte3 wrap", 32'(d), 32'h1A);
    i2c_stop();
    tick(4);
    check("sn read_done pulses", 32'(rd_hi - rd0), 32'h1);

    // Write 0x01, repeated START, 2-byte read of 0x0F0F
    wv0 = wv_hi;
    i2c_start();
    write_byte(8'h90, ack);
    check("sr wr addr ack", 32'(ack), 32'h0);
    write_byte(8'h01, ack);
    check("sr wr data ack", 32'(ack), 32'h0);
    sensor = 16'h0F0F;
    i2c_start();
    write_byte(8'h91, ack);
    check("sr rd addr ack", 32'(ack), 32'h0);
    read_byte(d, 1'b0);
    check("sr byte1", 32'(d), 32'h0F);
    read_byte(d, 1'b1);
    check("sr byte2", 32'(d), 32'h0F);
    i2c_stop();
    tick(4);
    check("sr write_data",  32'(bus.write_data), 32'h01);
    check("sr write_valid", 32'(wv_hi - wv0),    32'h1);

    // Async reset while the target drives bit 5 (0) of byte 1
    sensor = 16'h1A80;
    i2c_start();
    write_byte(8'h91, ack);
    check("rs addr ack", 32'(ack), 32'h0);
    read_bit(b);
    read_bit(b);
    sda_ctrl = 1'b1; tick(Q);
    scl      = 1'b1; tick(Q);
    check("rs driving before reset", 32'(bus.sda_oe), 32'h1);
    rst = 1'b0;
    #1;
    check("rs sda_oe released", 32'(bus.sda_oe), 32'h0);
    check("rs busy cleared",    32'(bus.busy),   32'h0);
    tick(3);
    scl = 1'b0; tick(Q);
    rst = 1'b1; tick(Q);
    i2c_stop();
    i2c_start();
    write_byte(8'h91, ack);
    check("rs again addr ack", 32'(ack), 32'h0);
    read_byte(d, 1'b0);
    check("rs again byte1", 32'(d), 32'h1A);
    read_byte(d, 1'b1);
    check("rs again byte2", 32'(d), 32'h80);
    i2c_stop();
    tick(4);

`ifdef I2C_TARGET_TIMEOUT_EN
    // SCL held low mid-read while the target pulls SDA for bit 7
    rd0 = rd_hi;
    i2c_start();
    write_byte(8'h91, ack);
    check("to addr ack", 32'(ack), 32'h0);
    check("to driving bit7", 32'(bus.sda_oe), 32'h1);
    tick(100);
    check("to sda_oe released", 32'(bus.sda_oe), 32'h0);
    check("to busy cleared",    32'(bus.busy),   32'h0);
    tick(20);
    i2c_stop();
    check("to no read_done", 32'(rd_hi - rd0), 32'h0);
    i2c_start();
    write_byte(8'h91, ack);
    check("to again addr ack", 32'(ack), 32'h0);
    read_byte(d, 1'b1);
    check("to again byte1", 32'(d), 32'h1A);
    i2c_stop();
    tick(4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
